// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port unified memory between instruction fetch and the LSU.
// One transaction in flight; define MEM_ARB_RR_EN for round-robin tie-breaking (default: data-first).
module mem_arbiter #(
    parameter int MEM_BYTES = 8192,
    parameter int MEM_LAT   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            if_req,
    input  logic [63:0]                     if_addr,
    output logic                            if_gnt,
    output logic                            if_rvalid,
    output logic [31:0]                     if_rdata,
    output logic                            if_fault,
    input  logic                            d_req,
    input  logic                            d_we,
    input  logic [63:0]                     d_addr,
    input  logic [63:0]                     d_wdata,
    input  logic [7:0]                      d_wstrb,
    output logic                            d_gnt,
    output logic                            d_rvalid,
    output logic [63:0]                     d_rdata,
    output logic                            d_fault,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [$clog2(MEM_BYTES)-4:0]    mem_addr,
    output logic [63:0]                     mem_wdata,
    output logic [7:0]                      mem_wstrb,
    input  logic [63:0]                     mem_rdata,
    output logic                            busy
);
    localparam int         AW    = $clog2(MEM_BYTES);
    localparam logic [2:0] LAT_C = 3'(MEM_LAT);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, FLT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       lane_hi_p1;
    logic       d_we_p1;
    logic       pick_d;
    logic       grant;
    logic       if_bad;
    logic       d_bad;
    logic       gnt_bad;
    logic       unused_addr_bits;

    // Byte lanes of a data access come from d_wstrb, so the low address bits carry no meaning.
    assign unused_addr_bits = ^d_addr[2:0];

    assign if_bad  = (|if_addr[63:AW]) | (|if_addr[1:0]);
    assign d_bad   = |d_addr[63:AW];
    assign busy    = (state != IDLE);

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // A tie goes to whoever was not granted last; reset leaves data first in line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b0;
        else if (grant)
            last_d <= d_gnt;
    end

    assign pick_d = d_req && !(if_req && last_d);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state == IDLE && !rst) begin
            d_gnt  = pick_d;
            if_gnt = if_req && !pick_d;
        end
    end

    assign grant   = if_gnt | d_gnt;
    assign gnt_bad = d_gnt ? d_bad : if_bad;

    // A faulting address never reaches the array; write payload is zero while the port is idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (if_gnt && !if_bad) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[AW-1:3];
        end else if (d_gnt && !d_bad) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[AW-1:3];
            mem_wdata = d_wdata;
            mem_wstrb = d_wstrb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_NONE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Response shaping only needs the fetch half-word select and the write flag.
    always_ff @(posedge clk) begin
        if (if_gnt)
            lane_hi_p1 <= if_addr[2];
        if (d_gnt)
            d_we_p1 <= d_we;
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        if_fault  = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_fault   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    owner_nxt = d_gnt ? OWN_D : OWN_IF;
                    if (gnt_bad) begin
                        state_nxt = FLT;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 3'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAT_C) begin
                    if (owner == OWN_IF) begin
                        if_rvalid = 1'b1;
                        if_rdata  = lane_hi_p1 ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else if (owner == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = d_we_p1 ? 64'd0 : mem_rdata;
                    end
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            FLT: begin
                if (owner == OWN_IF) begin
                    if_rvalid = 1'b1;
                    if_fault  = 1'b1;
                    if_rdata  = NOP;
                end else if (owner == OWN_D) begin
                    d_rvalid = 1'b1;
                    d_fault  = 1'b1;
                end
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = OWN_NONE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vector table, arbitration and reset sequences,
// then random traffic checked against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int MB  = 8192;
    localparam int LAT = 1;
    localparam int NW  = MB / 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, if_req, d_req, d_we;
    logic [63:0] if_addr, d_addr, d_wdata, mem_rdata, mem_wdata, d_rdata;
    logic [7:0]  d_wstrb, mem_wstrb;
    logic        if_gnt, if_rvalid, if_fault, d_gnt, d_rvalid, d_fault;
    logic        mem_en, mem_we, busy;
    logic [31:0] if_rdata;
    logic [9:0]  mem_addr;

    logic        r3_rst, d_req3;
    logic [63:0] d_addr3;
    logic        if_gnt3, if_rvalid3, if_fault3, d_gnt3, d_rvalid3, d_fault3;
    logic        mem_en3, mem_we3, busy3;
    logic [31:0] if_rdata3;
    logic [63:0] d_rdata3, mem_wdata3;
    logic [7:0]  mem_wstrb3;
    logic [9:0]  mem_addr3;
    localparam logic [63:0] RD3 = 64'h0123_4567_89AB_CDEF;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_BYTES(MB), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_fault(if_fault),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_fault(d_fault),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.MEM_BYTES(MB), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(r3_rst),
        .if_req(1'b0), .if_addr(64'd0), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
        .if_rdata(if_rdata3), .if_fault(if_fault3),
        .d_req(d_req3), .d_we(1'b0), .d_addr(d_addr3), .d_wdata(64'd0), .d_wstrb(8'd0),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_fault(d_fault3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_wstrb(mem_wstrb3), .mem_rdata(RD3), .busy(busy3)
    );

    function automatic logic [63:0] init_word(input int i);
        if (i == 0) return 64'hAAAA_BBBB_0000_0093;
        if (i == 2) return 64'h0;
        return {32'hC0DE_0000 + 32'(i), 32'hF00D_0000 + 32'(i)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Memory macro stand-in with one cycle of read latency
    logic [63:0] bmem [0:NW-1];
    logic [63:0] rd_q;
    logic        init_mem;
    assign mem_rdata = rd_q;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < NW; i++) bmem[i] <= init_word(i);
        end else if (mem_en) begin
            rd_q <= bmem[mem_addr];
            if (mem_we) bmem[mem_addr] <= merge(bmem[mem_addr], mem_wdata, mem_wstrb);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one pending response plus the cycle the port frees up
    logic [63:0] ref_mem [0:NW-1];
    int          t, m_free, m_resp_t;
    bit          m_resp_d, m_resp_f, m_last_d;
    logic [63:0] m_resp_q;
    logic        e_busy, e_ig, e_dg, e_en, e_we, e_iv, e_ifl, e_dv, e_dfl;
    logic [9:0]  e_ma;
    logic [63:0] e_wd, e_dq;
    logic [7:0]  e_ws;
    logic [31:0] e_id;
    bit          prev_ig, prev_dg;

    task automatic model_step();
        bit          pick, flt;
        logic [63:0] a, w;
        int          idx;
        e_busy = (t < m_free);
        e_ig = 0; e_dg = 0; e_en = 0; e_we = 0; e_ma = '0; e_wd = '0; e_ws = '0;
        e_iv  = (m_resp_t == t) && !m_resp_d;
        e_dv  = (m_resp_t == t) && m_resp_d;
        e_id  = e_iv ? m_resp_q[31:0] : 32'd0;
        e_dq  = e_dv ? m_resp_q : 64'd0;
        e_ifl = e_iv && m_resp_f;
        e_dfl = e_dv && m_resp_f;
        if (!e_busy && (if_req || d_req)) begin
            pick = d_req && !(if_req && RR && m_last_d);
            a    = pick ? d_addr : if_addr;
            flt  = (a >= 64'(MB)) || (!pick && a[1:0] != 2'b00);
            e_ig = !pick;
            e_dg = pick;
            m_last_d = pick;
            m_resp_d = pick;
            m_resp_f = flt;
            if (flt) begin
                m_resp_t = t + 1;
                m_free   = t + 2;
                m_resp_q = pick ? 64'd0 : 64'h13;
            end else begin
                idx  = int'(a >> 3);
                e_en = 1;
                e_ma = 10'(idx);
                w    = ref_mem[idx];
                if (pick) begin
                    e_we = d_we; e_wd = d_wdata; e_ws = d_wstrb;
                    if (d_we) begin
                        m_resp_q = 64'd0;
                        ref_mem[idx] = merge(w, d_wdata, d_wstrb);
                    end else begin
                        m_resp_q = w;
                    end
                end else begin
                    m_resp_q = a[2] ? {32'd0, w[63:32]} : {32'd0, w[31:0]};
                end
                m_resp_t = t + LAT;
                m_free   = t + LAT + 1;
            end
        end
        t++;
    endtask

    function automatic logic [63:0] gen_addr(input bit fetch);
        int r;
        logic [63:0] a;
        r = $urandom_range(0, 15);
        if (r == 0)
            a = 64'(MB) + 64'($urandom_range(0, 64));
        else if (r == 1)
            a = {$urandom, $urandom};
        else if (fetch)
            a = 64'(32 + 8 * $urandom_range(0, 15) + 4 * $urandom_range(0, 1));
        else
            a = 64'(32 + 8 * $urandom_range(0, 15) + $urandom_range(0, 7));
        if (fetch && r == 2) a[0] = 1'b1;
        return a;
    endfunction

    task automatic reset_all();
        @(negedge clk);
        rst = 1; if_req = 0; d_req = 0;
        @(negedge clk);
        rst = 0;
        t = 0; m_free = 0; m_resp_t = -1; m_last_d = 0; prev_ig = 0; prev_dg = 0;
    endtask

    typedef struct {
        logic ir; logic [63:0] ia; logic dr; logic dw; logic [63:0] da; logic [63:0] dd; logic [7:0] ds;
        logic ig; logic dg; logic en; logic we; logic [9:0] ma;
        logic iv; logic [31:0] id; logic ifl;
        logic dv; logic [63:0] dq; logic dfl; logic bz;
    } vec_t;

    vec_t        tbl [0:15];
    logic [7:0]  gseq [0:3];
    logic [7:0]  gexp;
    int          ng, last_c, ign;
    localparam logic [63:0] W = 64'h1122_3344_5566_7788;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        init_mem = 1; rst = 1; r3_rst = 1; d_req3 = 0; d_addr3 = 0;
        if_req = 1; if_addr = 64'h4; d_req = 1; d_we = 1; d_addr = 64'h10;
        d_wdata = W; d_wstrb = 8'hFF;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        #7;
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
        @(negedge clk);
        init_mem = 0;

        // Directed vectors, one per cycle
        tbl[0]  = '{0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0};
        tbl[1]  = '{1,64'h4,0,0,0,0,0, 1,0,1,0,0, 0,0,0, 0,0,0, 0};
        tbl[2]  = '{0,0,1,1,64'h10,W,8'h0F, 0,0,0,0,0, 1,32'hAAAABBBB,0, 0,0,0, 1};
        tbl[3]  = '{0,0,1,1,64'h10,W,8'h0F, 0,1,1,1,2, 0,0,0, 0,0,0, 0};
        tbl[4]  = '{0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 1};
        tbl[5]  = '{0,0,1,0,64'h13,0,0, 0,1,1,0,2, 0,0,0, 0,0,0, 0};
        tbl[6]  = '{0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,64'h55667788,0, 1};
        tbl[7]  = '{1,64'h2000,0,0,0,0,0, 1,0,0,0,0, 0,0,0, 0,0,0, 0};
        tbl[8]  = '{0,0,0,0,0,0,0, 0,0,0,0,0, 1,32'h13,1, 0,0,0, 1};
        tbl[9]  = '{0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0};
        tbl[10] = '{0,0,1,0,64'h2000,0,0, 0,1,0,0,0, 0,0,0, 0,0,0, 0};
        tbl[11] = '{0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 1,0,1, 1};
        tbl[12] = '{1,64'h6,0,0,0,0,0, 1,0,0,0,0, 0,0,0, 0,0,0, 0};
        tbl[13] = '{0,0,0,0,0,0,0, 0,0,0,0,0, 1,32'h13,1, 0,0,0, 1};
        tbl[14] = '{1,64'h1C,0,0,0,0,0, 1,0,1,0,3, 0,0,0, 0,0,0, 0};
        tbl[15] = '{0,0,0,0,0,0,0, 0,0,0,0,0, 1,32'hC0DE0003,0, 0,0,0, 1};

        reset_all();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if_req = tbl[k].ir; if_addr = tbl[k].ia; d_req = tbl[k].dr; d_we = tbl[k].dw;
            d_addr = tbl[k].da; d_wdata = tbl[k].dd; d_wstrb = tbl[k].ds;
            #2;
            chk($sformatf("v%0d_if_gnt", k), if_gnt, tbl[k].ig);
            chk($sformatf("v%0d_d_gnt", k), d_gnt, tbl[k].dg);
            chk($sformatf("v%0d_mem_en", k), mem_en, tbl[k].en);
            chk($sformatf("v%0d_mem_we", k), mem_we, tbl[k].we);
            chk($sformatf("v%0d_mem_wstrb", k), mem_wstrb, (tbl[k].en && tbl[k].dg) ? tbl[k].ds : 8'd0);
            if (tbl[k].en) chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].ma);
            chk($sformatf("v%0d_if_rvalid", k), if_rvalid, tbl[k].iv);
            chk($sformatf("v%0d_if_rdata", k), if_rdata, tbl[k].id);
            chk($sformatf("v%0d_if_fault", k), if_fault, tbl[k].ifl);
            chk($sformatf("v%0d_d_rvalid", k), d_rvalid, tbl[k].dv);
            chk($sformatf("v%0d_d_rdata", k), d_rdata, tbl[k].dq);
            chk($sformatf("v%0d_d_fault", k), d_fault, tbl[k].dfl);
            chk($sformatf("v%0d_busy", k), busy, tbl[k].bz);
        end

        // Both requesters held: grant order and back-to-back spacing
        reset_all();
        if_req = 1; if_addr = 64'h0; d_req = 1; d_we = 0; d_addr = 64'h8; d_wdata = 0; d_wstrb = 0;
        ng = 0; last_c = -1; ign = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            @(negedge clk);
            #2;
            chk("arb_one_grant", {if_gnt, d_gnt} == 2'b11, 0);
            if (if_gnt) ign++;
            if (if_gnt || d_gnt) begin
                gseq[ng] = d_gnt ? "D" : "I";
                if (ng > 0) chk("arb_gap", c - last_c, LAT + 1);
                last_c = c;
                ng++;
            end
        end
        if_req = 0; d_req = 0;
        chk("arb_count", ng, 4);
        for (int k = 0; k < 4 && k < ng; k++) begin
            gexp = (RR && (k % 2 == 1)) ? "I" : "D";
            chk($sformatf("arb_order%0d", k), gseq[k], gexp);
        end
`ifndef MEM_ARB_RR_EN
        chk("arb_no_if_gnt", ign, 0);
`endif

        // Random traffic against the reference model
        reset_all();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!if_req || prev_ig) begin
                if_req = ($urandom % 3) != 0;
                if_addr = gen_addr(1'b1);
            end else if ($urandom % 12 == 0) begin
                if_req = 0;
            end
            if (!d_req || prev_dg) begin
                d_req = ($urandom % 3) != 0;
                d_addr = gen_addr(1'b0);
                d_we = $urandom % 2;
                d_wdata = {$urandom, $urandom};
                d_wstrb = 8'($urandom);
            end else if ($urandom % 12 == 0) begin
                d_req = 0;
            end
            #2;
            model_step();
            chk("rnd_if_gnt", if_gnt, e_ig);
            chk("rnd_d_gnt", d_gnt, e_dg);
            chk("rnd_mem_en", mem_en, e_en);
            chk("rnd_mem_addr", mem_addr, e_ma);
            chk("rnd_mem_we", mem_we, e_we);
            chk("rnd_mem_wdata", mem_wdata, e_wd);
            chk("rnd_mem_wstrb", mem_wstrb, e_ws);
            chk("rnd_if_rvalid", if_rvalid, e_iv);
            chk("rnd_if_rdata", if_rdata, e_id);
            chk("rnd_if_fault", if_fault, e_ifl);
            chk("rnd_d_rvalid", d_rvalid, e_dv);
            chk("rnd_d_rdata", d_rdata, e_dq);
            chk("rnd_d_fault", d_fault, e_dfl);
            chk("rnd_busy", busy, e_busy);
            prev_ig = e_ig;
            prev_dg = e_dg;
        end
        if_req = 0; d_req = 0;

        // MEM_LAT=3 instance: reset pulse while a read is in flight
        @(negedge clk);
        r3_rst = 0;
        @(negedge clk);
        d_req3 = 1; d_addr3 = 64'h8;
        #2;
        chk("r3_gnt_T", d_gnt3, 1);
        chk("r3_mem_en_T", mem_en3, 1);
        @(negedge clk);
        d_req3 = 0;
        #1;
        chk("r3_busy_T1", busy3, 1);
        r3_rst = 1;
        #1;
        chk("r3_busy_in_rst", busy3, 0);
        chk("r3_rvalid_in_rst", d_rvalid3, 0);
        @(negedge clk);
        r3_rst = 0; d_req3 = 1; d_addr3 = 64'h10;
        #2;
        chk("r3_gnt_after_rst", d_gnt3, 1);
        chk("r3_mem_addr", mem_addr3, 2);
        @(negedge clk);
        d_req3 = 0;
        #2;
        chk("r3_no_rvalid_T3", d_rvalid3, 0);
        chk("r3_busy_T3", busy3, 1);
        @(negedge clk);
        #2;
        chk("r3_no_rvalid_T4", d_rvalid3, 0);
        @(negedge clk);
        #2;
        chk("r3_rvalid_new", d_rvalid3, 1);
        chk("r3_rdata_new", d_rdata3, RD3);
        @(negedge clk);
        #2;
        chk("r3_idle", busy3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
